// File: rtl/turn_signal_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : turn_signal_sequencer
// Description : Drives the six tail-light lamps from the 2-bit light-mode
//               code. A prescaler sets the animation step rate. Left and
//               right run a 3-lamp outward chase, and hazard flashes all six
//               lamps together.
//
//   Ports
//     clock          in   1   system clock, rising-edge active
//     reset          in   1   synchronous, active-low reset
//     current_state  in   2   00 idle, 01 left, 10 right, 11 hazard
//     LEDR           out  10  [5:3] left lamps (3 inner, 5 outer),
//                             [2:0] right lamps (2 inner, 0 outer),
//                             [9:6] unused, always 0
//
//   Parameters
//     TICK_DIV       clock cycles per animation step (>= 1)
//
// Revision    : 1.0  initial release
// ============================================================================
module turn_signal_sequencer #(
    parameter int TICK_DIV = 12500000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] current_state,
    output logic [9:0] LEDR
);

    // A divider of 1 still needs a 1-bit counter to keep the logic uniform.
    localparam int c_CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TICK_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ZERO = '0;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [1:0] c_MODE_IDLE   = 2'b00;
    localparam logic [1:0] c_MODE_LEFT   = 2'b01;
    localparam logic [1:0] c_MODE_RIGHT  = 2'b10;
    localparam logic [1:0] c_MODE_HAZARD = 2'b11;

    logic [1:0]         r_mode;
    logic [c_CNT_W-1:0] r_div_cnt;
    logic [1:0]         r_step;
    logic [9:0]         w_ledr;

    // Priority order is reset, then mode change, then the idle hold, then the
    // prescaler tick. The mode input is sampled directly, so a pulse that
    // returns to the old value between edges never restarts the animation.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_mode    <= c_MODE_IDLE;
            r_div_cnt <= c_CNT_ZERO;
            r_step    <= 2'd0;
        end else if (current_state != r_mode) begin
            r_mode    <= current_state;
            r_div_cnt <= c_CNT_ZERO;
            r_step    <= 2'd0;
        end else if (r_mode == c_MODE_IDLE) begin
            r_div_cnt <= c_CNT_ZERO;
            r_step    <= 2'd0;
        end else if (r_div_cnt == c_CNT_LAST) begin
            r_div_cnt <= c_CNT_ZERO;
            // Two-bit wrap gives the 4-phase chase. Hazard uses only bit 0.
            r_step    <= r_step + 2'd1;
        end else begin
            r_div_cnt <= r_div_cnt + c_CNT_ONE;
        end
    end

    // Lamp pattern is a pure decode of the registered state, so the new
    // pattern appears on the same edge that updates the registers.
    always_comb begin
        w_ledr = 10'd0;
        case (r_mode)
            c_MODE_LEFT: begin
                case (r_step)
                    2'd0:    w_ledr[5:3] = 3'b000;
                    2'd1:    w_ledr[5:3] = 3'b001;
                    2'd2:    w_ledr[5:3] = 3'b011;
                    default: w_ledr[5:3] = 3'b111;
                endcase
            end
            c_MODE_RIGHT: begin
                case (r_step)
                    2'd0:    w_ledr[2:0] = 3'b000;
                    2'd1:    w_ledr[2:0] = 3'b100;
                    2'd2:    w_ledr[2:0] = 3'b110;
                    default: w_ledr[2:0] = 3'b111;
                endcase
            end
            c_MODE_HAZARD: begin
                w_ledr[5:0] = r_step[0] ? 6'b000000 : 6'b111111;
            end
            default: begin
                w_ledr = 10'd0;
            end
        endcase
    end

    assign LEDR = w_ledr;

endmodule
`default_nettype wire

// File: tb/tb_turn_signal_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_turn_signal_sequencer
// Description : Directed self-checking bench for turn_signal_sequencer.
//               One instance uses TICK_DIV=4 and another uses TICK_DIV=1.
// Revision    : 1.0  initial release
// ============================================================================
module tb_turn_signal_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] cs4;
    logic [1:0] cs1;
    logic [9:0] ledr4;
    logic [9:0] ledr1;

    int n_vec = 0;
    int n_err = 0;

    // Hand-computed lamp patterns, indexed by the animation step.
    logic [9:0] c_LEFT  [4] = '{10'h000, 10'h008, 10'h018, 10'h038};
    logic [9:0] c_RIGHT [4] = '{10'h000, 10'h004, 10'h006, 10'h007};

    turn_signal_sequencer #(.TICK_DIV(4)) u_dut4 (
        .clock         (clock),
        .reset         (reset),
        .current_state (cs4),
        .LEDR          (ledr4)
    );

    turn_signal_sequencer #(.TICK_DIV(1)) u_dut1 (
        .clock         (clock),
        .reset         (reset),
        .current_state (cs1),
        .LEDR          (ledr1)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %b, expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one rising edge and settle before sampling.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        cs4   = 2'b11;
        cs1   = 2'b00;

        // Reset held for two edges
        tick();
        check("reset_e1", ledr4, 10'h000);
        tick();
        check("reset_e2", ledr4, 10'h000);
        check("reset_d1", ledr1, 10'h000);

        // Release into idle
        reset = 1'b1;
        cs4   = 2'b00;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("idle", ledr4, 10'h000);
        end

        // Left chase, edge N is the first tick
        cs4 = 2'b01;
        for (int k = 0; k <= 16; k++) begin
            tick();
            check("left", ledr4, c_LEFT[(k / 4) % 4]);
        end

        // Right chase
        cs4 = 2'b10;
        for (int k = 0; k <= 16; k++) begin
            tick();
            check("right", ledr4, c_RIGHT[(k / 4) % 4]);
        end

        // Hazard flash
        cs4 = 2'b11;
        for (int k = 0; k <= 16; k++) begin
            tick();
            check("hazard", ledr4, ((k / 4) % 2 == 0) ? 10'h03F : 10'h000);
        end

        // Left up to step 2, then switch to right
        cs4 = 2'b01;
        for (int k = 0; k < 9; k++) tick();
        check("left_s2", ledr4, 10'h018);
        cs4 = 2'b10;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("l2r_restart", ledr4, 10'h000);
        end
        tick();
        check("l2r_first", ledr4, 10'h004);

        // Left up to step 2, then switch to idle
        cs4 = 2'b01;
        for (int k = 0; k < 9; k++) tick();
        check("left_s2b", ledr4, 10'h018);
        cs4 = 2'b00;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("l2idle", ledr4, 10'h000);
        end

        // Reset during hazard on-phase with a simultaneous mode change
        cs4 = 2'b11;
        tick();
        tick();
        check("haz_on", ledr4, 10'h03F);
        reset = 1'b0;
        cs4   = 2'b01;
        tick();
        check("reset_wins", ledr4, 10'h000);
        reset = 1'b1;
        cs4   = 2'b11;
        tick();
        check("haz_restart", ledr4, 10'h03F);
        tick();
        check("haz_hold", ledr4, 10'h03F);

        // Divider of one, left chase advances every edge
        cs1 = 2'b01;
        for (int k = 0; k < 9; k++) begin
            tick();
            check("div1_left", ledr1, c_LEFT[k % 4]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
